router_out_fifo: RTL and testbench

- Per-destination output buffer of the 1x3 router; one instance per output port (three total).
- Sits directly downstream of the register stage and captures its dout byte stream, including the header, payload and parity bytes.
- Tags each header byte on write, using lfd_state, so the read side can track packet boundaries.
- The read side is drained by the destination client; the read side reports when a packet is in flight.

---
 rtl/router_out_fifo_pkg.sv | 23 ++
 rtl/router_fifo_mem.sv | 49 ++++
 rtl/router_out_fifo.sv | 107 ++++++++++
 tb/tb_router_out_fifo.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/router_out_fifo_pkg.sv
// Shared router definitions: header length field and the tagged FIFO word.
// Imported by the per-port output FIFO and its storage array.
package router_out_fifo_pkg;

  localparam int HDR_LEN_MSB  = 7;
  localparam int HDR_LEN_LSB  = 2;
  localparam int HDR_LEN_W    = HDR_LEN_MSB - HDR_LEN_LSB + 1;
  localparam int ADDR_FIELD_W = 2;
  localparam int BYTE_CNT_W   = 7;

  typedef struct packed {
    logic       tag;
    logic [7:0] data;
  } fifo_word_t;

  // Header length counts payload only; parity adds one more byte.
  function automatic logic [BYTE_CNT_W-1:0] hdr_len(
    input logic [HDR_LEN_W-1:0] len
  );
    return {1'b0, len} + 7'd1;
  endfunction

endpackage

// File: rtl/router_fifo_mem.sv
// DEPTH x 9 dual-port array: one write port, one async read port.
// Data bytes carry no reset; header tag bits reset and flush to zero.
module router_fifo_mem
  import router_out_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  fifo_word_t        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output fifo_word_t        rdata
);

  logic [7:0]       data_q [DEPTH];
  logic [DEPTH-1:0] tag_q;
  logic [DEPTH-1:0] tag_d;

  always_ff @(posedge clk) begin
    if (we) begin
      data_q[waddr] <= wdata.data;
    end
  end

  always_comb begin
    tag_d = tag_q;
    if (clr) begin
      tag_d = '0;
    end else if (we) begin
      tag_d[waddr] = wdata.tag;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q <= '0;
    end else begin
      tag_q <= tag_d;
    end
  end

  assign rdata.tag  = tag_q[raddr];
  assign rdata.data = data_q[raddr];

endmodule

// File: rtl/router_out_fifo.sv
// Per-destination output FIFO of the 1x3 router.
// Tags headers on write and tracks packet progress on the read side.
module router_out_fifo
  import router_out_fifo_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       soft_reset,
  input  logic       write_enb,
  input  logic       lfd_state,
  input  logic [7:0] data_in,
  input  logic       read_enb,
  output logic [7:0] data_out,
  output logic       full,
  output logic       empty,
  output logic       pkt_active
);

  localparam int PW = ADDR_W + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [BYTE_CNT_W-1:0] byte_cnt_q, byte_cnt_d;
  logic [7:0]            dout_q, dout_d;

  logic       wr_acc;
  logic       rd_acc;
  logic       mem_we;
  fifo_word_t wr_word;
  fifo_word_t rd_word;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0])
              && (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]);

  assign wr_acc = write_enb && !full;
  assign rd_acc = read_enb && !empty;
  assign mem_we = wr_acc && !soft_reset;

  assign wr_word.tag  = lfd_state;
  assign wr_word.data = data_in;

  router_fifo_mem #(
    .DEPTH (DEPTH),
    .ADDR_W(ADDR_W)
  ) u_mem (
    .clk  (clk),
    .rst  (rst),
    .clr  (soft_reset),
    .we   (mem_we),
    .waddr(wr_ptr_q[ADDR_W-1:0]),
    .wdata(wr_word),
    .raddr(rd_ptr_q[ADDR_W-1:0]),
    .rdata(rd_word)
  );

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    byte_cnt_d = byte_cnt_q;
    dout_d     = dout_q;
    if (soft_reset) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      byte_cnt_d = '0;
      dout_d     = 8'h00;
    end else begin
      if (wr_acc) begin
        wr_ptr_d = wr_ptr_q + PTR_ONE;
      end
      if (rd_acc) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        dout_d   = rd_word.data;
        // A header always reloads, even over a truncated packet.
        if (rd_word.tag) begin
          byte_cnt_d = hdr_len(rd_word.data[HDR_LEN_MSB:HDR_LEN_LSB]);
        end else if (byte_cnt_q != '0) begin
          byte_cnt_d = byte_cnt_q - 7'd1;
        end
      end else if (byte_cnt_q == '0) begin
        dout_d = 8'h00;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      byte_cnt_q <= '0;
      dout_q     <= 8'h00;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      byte_cnt_q <= byte_cnt_d;
      dout_q     <= dout_d;
    end
  end

  assign data_out   = dout_q;
  assign pkt_active = (byte_cnt_q != '0);

endmodule

// File: tb/tb_router_out_fifo.sv
// Directed bench for router_out_fifo: vector table plus
// hand-written fill, wrap, collision, flush and counter sequences.
module tb_router_out_fifo;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       soft_reset = 1'b0;
  logic       write_enb = 1'b0;
  logic       lfd_state = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       read_enb = 1'b0;
  logic [7:0] data_out;
  logic       full;
  logic       empty;
  logic       pkt_active;

  int total = 0;
  int bad = 0;

  router_out_fifo #(
    .DEPTH (16),
    .ADDR_W(4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .soft_reset(soft_reset),
    .write_enb (write_enb),
    .lfd_state (lfd_state),
    .data_in   (data_in),
    .read_enb  (read_enb),
    .data_out  (data_out),
    .full      (full),
    .empty     (empty),
    .pkt_active(pkt_active)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic       lfd;
    logic [7:0] din;
    logic       re;
    logic [7:0] dout;
    logic       full;
    logic       empty;
    logic       act;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(
    input logic we, input logic lfd, input logic [7:0] din,
    input logic re, input logic [7:0] dout,
    input logic f, input logic e, input logic a
  );
    vec_t v;
    v.we = we; v.lfd = lfd; v.din = din; v.re = re;
    v.dout = dout; v.full = f; v.empty = e; v.act = a;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic st(input string nm, input logic [7:0] d,
                    input logic f, input logic e, input logic a);
    chk({nm, ".dout"}, data_out, d);
    chk({nm, ".full"}, {7'd0, full}, {7'd0, f});
    chk({nm, ".empty"}, {7'd0, empty}, {7'd0, e});
    chk({nm, ".act"}, {7'd0, pkt_active}, {7'd0, a});
  endtask

  task automatic drive(input logic we, input logic lfd,
                       input logic [7:0] d, input logic re,
                       input logic sr);
    write_enb = we; lfd_state = lfd; data_in = d;
    read_enb = re; soft_reset = sr;
    @(posedge clk);
    #1;
    write_enb = 1'b0; lfd_state = 1'b0; data_in = 8'h00;
    read_enb = 1'b0; soft_reset = 1'b0;
  endtask

  initial begin
    #3;
    st("por", 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Mid-stream async reset
    drive(1, 0, 8'hAB, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    chk("pre_rst.dout", data_out, 8'hAB);
    drive(1, 0, 8'hCD, 0, 0);
    drive(1, 0, 8'hCE, 0, 0);
    #2 rst = 1'b0;
    #1;
    st("async_rst", 8'h00, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // Basic packet, orphan, paused packet, truncated packet
    tbl.push_back(mk(1, 1, 8'h0E, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h11, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h22, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h33, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h0A, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0E, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h11, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h22, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h33, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h0A, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 0, 8'h5A, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h5A, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h04, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 0, 8'h77, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h04, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 1, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h77, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'h88, 0, 8'h77, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h88, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(1, 1, 8'h10, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(1, 1, 8'h04, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h10, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'h04, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'hB1, 0, 8'h04, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hB1, 0, 1, 1));
    tbl.push_back(mk(1, 0, 8'hC2, 0, 8'hB1, 0, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 1, 8'hC2, 0, 1, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 8'h00, 0, 1, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].we, tbl[i].lfd, tbl[i].din, tbl[i].re, 1'b0);
      st($sformatf("vec%0d", i), tbl[i].dout, tbl[i].full,
         tbl[i].empty, tbl[i].act);
    end

    // Fill and overflow
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i), 0, 0);
      chk($sformatf("fill%0d.full", i), {7'd0, full},
          {7'd0, (i == 15)});
    end
    drive(1, 0, 8'hFF, 0, 0);
    chk("ovf.full", {7'd0, full}, 8'd1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("drain%0d", i), data_out, 8'(i));
    end
    st("drained", 8'h0F, 1'b0, 1'b1, 1'b0);

    // Wrap-around
    for (int i = 0; i < 10; i++) drive(1, 0, 8'h20 + 8'(i), 0, 0);
    for (int i = 0; i < 10; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("wrapA%0d", i), data_out, 8'h20 + 8'(i));
    end
    for (int i = 0; i < 12; i++) begin
      drive(1, 0, 8'h40 + 8'(i), 0, 0);
      chk($sformatf("wrapW%0d.fe", i), {6'd0, full, empty}, 8'd0);
    end
    for (int i = 0; i < 12; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("wrapB%0d", i), data_out, 8'h40 + 8'(i));
    end
    chk("wrap.empty", {7'd0, empty}, 8'd1);

    // Simultaneous read/write at full, then at empty
    for (int i = 0; i < 16; i++) drive(1, 0, 8'h80 + 8'(i), 0, 0);
    chk("coll.full", {7'd0, full}, 8'd1);
    drive(1, 0, 8'h55, 1, 0);
    st("coll_full", 8'h80, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i < 16; i++) begin
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("coll%0d", i), data_out, 8'h80 + 8'(i));
    end
    chk("coll.empty", {7'd0, empty}, 8'd1);
    drive(1, 0, 8'h66, 1, 0);
    st("coll_empty", 8'h00, 1'b0, 1'b0, 1'b0);
    drive(0, 0, 8'h00, 1, 0);
    st("coll_66", 8'h66, 1'b0, 1'b1, 1'b0);

    // soft_reset mid-packet, beating a same-cycle read and write
    drive(1, 1, 8'h14, 0, 0);
    for (int i = 1; i <= 6; i++) drive(1, 0, 8'hA0 + 8'(i), 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    st("pre_sr", 8'h14, 1'b0, 1'b0, 1'b1);
    drive(1, 0, 8'hEE, 1, 1);
    st("sr", 8'h00, 1'b0, 1'b1, 1'b0);
    drive(0, 0, 8'h00, 0, 0);
    st("post_sr", 8'h00, 1'b0, 1'b1, 1'b0);

    // Maximum header length: 63 payload + parity
    drive(1, 1, 8'hFC, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    st("max_hdr", 8'hFC, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 64; i++) begin
      drive(1, 0, 8'(i), 0, 0);
      drive(0, 0, 8'h00, 1, 0);
      chk($sformatf("max%0d.dout", i), data_out, 8'(i));
      chk($sformatf("max%0d.act", i), {7'd0, pkt_active},
          {7'd0, (i != 63)});
    end
    drive(0, 0, 8'h00, 0, 0);
    st("max_idle", 8'h00, 1'b0, 1'b1, 1'b0);
    drive(1, 0, 8'h3C, 0, 0);
    drive(0, 0, 8'h00, 1, 0);
    st("orphan", 8'h3C, 1'b0, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
